// File: rtl/acc_relu_maxpool.sv
// ---------------------------------------------------------------------------
// acc_relu_maxpool
//
// Streaming post-processing stage placed after the channel accumulator.
// Takes saturated signed pixels in raster order, one per valid beat, and
// applies ReLU followed by 2x2 / stride-2 max pooling. Pooled pixels leave
// one cycle after the beat that closes their window. The stage never stalls
// its source.
//
// Build option:
//   RELU_EN  - when defined, negative inputs are clamped to zero before
//              pooling. When undefined, pooling works on raw signed inputs.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   ofmap_w_i      frame width minus 1  (sampled on the first beat of a frame)
//   ofmap_h_i      frame height minus 1 (sampled on the first beat of a frame)
//   conv_valid_i   input beat valid
//   conv_result_i  signed input pixel
//   last_i         final pixel of the frame, qualified by conv_valid_i
//   pool_valid_o   one-cycle pulse per pooled pixel
//   pool_data_o    signed pooled pixel
//   pool_last_o    final pooled pixel of the frame, qualified by pool_valid_o
//   err_o          sticky framing error, cleared only by rst
// ---------------------------------------------------------------------------
module acc_relu_maxpool #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 28,
    parameter int DIM_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  ofmap_w_i,
    input  logic [DIM_W-1:0]  ofmap_h_i,
    input  logic              conv_valid_i,
    input  logic [DATA_W-1:0] conv_result_i,
    input  logic              last_i,
    output logic              pool_valid_o,
    output logic [DATA_W-1:0] pool_data_o,
    output logic              pool_last_o,
    output logic              err_o
);

    localparam int LB_DEPTH = MAX_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [0:0]               state_r;
    logic [DIM_W-1:0]         w_m1_r;
    logic [DIM_W-1:0]         h_m1_r;
    logic [DIM_W-1:0]         col_r;
    logic [DIM_W-1:0]         row_r;
    logic signed [DATA_W-1:0] h_reg_r;
    logic signed [DATA_W-1:0] linebuf_r [LB_DEPTH];
    logic                     pool_valid_r;
    logic [DATA_W-1:0]        pool_data_r;
    logic                     pool_last_r;
    logic                     err_r;

    logic [DIM_W-1:0]         w_m1_s;
    logic [DIM_W-1:0]         h_m1_s;
    logic [DIM_W-1:0]         last_col_s;
    logic [DIM_W-1:0]         last_row_s;
    logic [LB_AW-1:0]         lb_idx_s;
    logic signed [DATA_W-1:0] pix_s;
    logic signed [DATA_W-1:0] pair_s;
    logic signed [DATA_W-1:0] quad_s;
    logic                     at_end_s;

    // Effective dimensions, ReLU, window maxima and end-of-frame detection.
    always_comb begin
        w_m1_s = w_m1_r;
        h_m1_s = h_m1_r;
        // The first beat of a frame is processed with the dimensions it carries.
        if (state_r == IDLE) begin
            w_m1_s = ofmap_w_i;
            h_m1_s = ofmap_h_i;
        end else begin
            w_m1_s = w_m1_r;
            h_m1_s = h_m1_r;
        end
`ifdef RELU_EN
        pix_s = conv_result_i[DATA_W-1] ? {DATA_W{1'b0}} : $signed(conv_result_i);
`else
        pix_s = $signed(conv_result_i);
`endif
        lb_idx_s = col_r[LB_AW:1];
        pair_s   = smax(h_reg_r, pix_s);
        quad_s   = smax(linebuf_r[lb_idx_s], pair_s);
        at_end_s = (row_r == h_m1_s) && (col_r == w_m1_s);
        // Last complete window closes at the last odd index; with an odd
        // dimension the trailing (even) index is discarded.
        last_col_s = w_m1_s[0] ? w_m1_s : (w_m1_s - {{(DIM_W-1){1'b0}}, 1'b1});
        last_row_s = h_m1_s[0] ? h_m1_s : (h_m1_s - {{(DIM_W-1){1'b0}}, 1'b1});
    end

    // Frame FSM, counters, horizontal hold register, outputs and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            w_m1_r       <= {DIM_W{1'b0}};
            h_m1_r       <= {DIM_W{1'b0}};
            col_r        <= {DIM_W{1'b0}};
            row_r        <= {DIM_W{1'b0}};
            h_reg_r      <= {DATA_W{1'b0}};
            pool_valid_r <= 1'b0;
            pool_data_r  <= {DATA_W{1'b0}};
            pool_last_r  <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            pool_valid_r <= 1'b0;
            pool_last_r  <= 1'b0;
            if (conv_valid_i) begin
                case (state_r)
                    IDLE: begin
                        w_m1_r <= ofmap_w_i;
                        h_m1_r <= ofmap_h_i;
                    end
                    RUN: begin
                        w_m1_r <= w_m1_r;
                        h_m1_r <= h_m1_r;
                    end
                    default: begin
                        w_m1_r <= ofmap_w_i;
                        h_m1_r <= ofmap_h_i;
                    end
                endcase

                // Even columns open a horizontal pair; odd columns on odd rows
                // close a 2x2 window (even/odd pairs go to the line buffer).
                if (!col_r[0]) begin
                    h_reg_r <= pix_s;
                end else if (row_r[0]) begin
                    pool_valid_r <= 1'b1;
                    pool_data_r  <= quad_s;
                    pool_last_r  <= (row_r == last_row_s) && (col_r == last_col_s);
                end else begin
                    h_reg_r <= h_reg_r;
                end

                // Frame ends on last_i or on the final raster position; a
                // disagreement between the two is a framing error.
                if (last_i || at_end_s) begin
                    state_r <= IDLE;
                    col_r   <= {DIM_W{1'b0}};
                    row_r   <= {DIM_W{1'b0}};
                    if (last_i != at_end_s) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                end else begin
                    state_r <= RUN;
                    if (col_r == w_m1_s) begin
                        col_r <= {DIM_W{1'b0}};
                        row_r <= row_r + {{(DIM_W-1){1'b0}}, 1'b1};
                    end else begin
                        col_r <= col_r + {{(DIM_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    // Line buffer of horizontal pair maxima from the even row; not reset
    // because every entry is written before it is read within a frame.
    always_ff @(posedge clk) begin
        if (!rst && conv_valid_i && !row_r[0] && col_r[0]) begin
            linebuf_r[lb_idx_s] <= pair_s;
        end
    end

    assign pool_valid_o = pool_valid_r;
    assign pool_data_o  = pool_data_r;
    assign pool_last_o  = pool_last_r;
    assign err_o        = err_r;

endmodule
